memoria_dp_param: RTL and testbench

//  Parametrised true dual-port synchronous RAM: two independent read/write ports on one clock.

---
 rtl/memoria_dp_param_if.sv | 41 ++++
 rtl/memoria_dp_param.sv | 172 +++++++++++++++++
 tb/tb_memoria_dp_param.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memoria_dp_param_if.sv
// Bus interface for memoria_dp_param: both RAM ports, the clear request and the status flags.
//   clr                     start a clear sweep
//   en_x/we_x/addr_x/data_x port x request (x = a, b)
//   q_x/valid_x             port x read data and result strobe
//   busy                    clear sweep in progress
//   collision               same-address conflict on the request now reported
// master: drives requests (user logic); slave: the RAM.
interface memoria_dp_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) ();
    logic              clr;
    logic              en_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] q_a;
    logic              valid_a;
    logic              en_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] q_b;
    logic              valid_b;
    logic              busy;
    logic              collision;

    modport master (
        output clr,
        output en_a, we_a, addr_a, data_a,
        output en_b, we_b, addr_b, data_b,
        input  q_a, valid_a, q_b, valid_b, busy, collision
    );

    modport slave (
        input  clr,
        input  en_a, we_a, addr_a, data_a,
        input  en_b, we_b, addr_b, data_b,
        output q_a, valid_a, q_b, valid_b, busy, collision
    );
endinterface

// File: rtl/memoria_dp_param.sv
// True dual-port synchronous RAM shared between the PCIe-side and user-side datapaths.
// Two independent read/write ports on one clock, selectable same-port read-during-write
// behaviour, optional output register, per-port valid strobes, A-over-B write arbitration with
// a collision flag, and a clear sweep that runs after reset and on request.
// Ports:
//   clk    single clock, all state on posedge
//   rst_n  asynchronous active-low reset (restarts the clear sweep)
//   bus    memoria_dp_param_if slave: requests, read data, valid, busy, collision
module memoria_dp_param #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       RDW_MODE = 0,
    parameter int unsigned       OUT_REG  = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input logic               clk,
    input logic               rst_n,
    memoria_dp_param_if.slave bus
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    // Same-port write returns the new data when set, the old contents otherwise.
    localparam bit                NewData  = (RDW_MODE == 0);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic acc_a, acc_b, wr_a, wr_b, wr_b_eff, same_addr, col;

    // ---------------------------------------------------------------- clear sweep FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        unique case (state_q)
            StClear: begin
                busy  = 1'b1;
                ptr_d = ptr_q + ADDR_W'(1);
                // The edge that clears the last word also leaves the sweep.
                if (ptr_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (bus.clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    assign bus.busy = busy;

    // ---------------------------------------------------------------- accept / arbitration
    assign acc_a     = bus.en_a & ~busy;
    assign acc_b     = bus.en_b & ~busy;
    assign wr_a      = acc_a & bus.we_a;
    assign wr_b      = acc_b & bus.we_b;
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign col       = acc_a & acc_b & same_addr & (bus.we_a | bus.we_b);
    // Port A owns the word when both write the same address.
    assign wr_b_eff  = wr_b & ~(wr_a & same_addr);

    // ---------------------------------------------------------------- storage (not reset)
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr_q] <= CLR_VAL;
        end else begin
            if (wr_a) begin
                mem[bus.addr_a] <= bus.data_a;
            end
            if (wr_b_eff) begin
                mem[bus.addr_b] <= bus.data_b;
            end
        end
    end

    // ---------------------------------------------------------------- first read stage
    // The array is sampled before this edge's writes land, so a cross-port reader of a word
    // being written sees the old contents.
    logic [DATA_W-1:0] q1_a_q, q1_a_d, q1_b_q, q1_b_d;
    logic              v1_a_q, v1_b_q, col1_q;

    always_comb begin
        q1_a_d = q1_a_q;
        q1_b_d = q1_b_q;
        if (acc_a) begin
            q1_a_d = (bus.we_a && NewData) ? bus.data_a : mem[bus.addr_a];
        end
        if (acc_b) begin
            q1_b_d = (bus.we_b && NewData) ? bus.data_b : mem[bus.addr_b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a_q <= '0;
            q1_b_q <= '0;
            v1_a_q <= 1'b0;
            v1_b_q <= 1'b0;
            col1_q <= 1'b0;
        end else begin
            q1_a_q <= q1_a_d;
            q1_b_q <= q1_b_d;
            v1_a_q <= acc_a;
            v1_b_q <= acc_b;
            col1_q <= col;
        end
    end

    // ---------------------------------------------------------------- optional output stage
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] q2_a_q, q2_a_d, q2_b_q, q2_b_d;
        logic              v2_a_q, v2_b_q, col2_q;

        // Data only advances with a valid result so q holds between strobes.
        always_comb begin
            q2_a_d = v1_a_q ? q1_a_q : q2_a_q;
            q2_b_d = v1_b_q ? q1_b_q : q2_b_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q2_a_q <= '0;
                q2_b_q <= '0;
                v2_a_q <= 1'b0;
                v2_b_q <= 1'b0;
                col2_q <= 1'b0;
            end else begin
                q2_a_q <= q2_a_d;
                q2_b_q <= q2_b_d;
                v2_a_q <= v1_a_q;
                v2_b_q <= v1_b_q;
                col2_q <= col1_q;
            end
        end

        assign bus.q_a       = q2_a_q;
        assign bus.q_b       = q2_b_q;
        assign bus.valid_a   = v2_a_q;
        assign bus.valid_b   = v2_b_q;
        assign bus.collision = col2_q;
    end else begin : g_no_out_reg
        assign bus.q_a       = q1_a_q;
        assign bus.q_b       = q1_b_q;
        assign bus.valid_a   = v1_a_q;
        assign bus.valid_b   = v1_b_q;
        assign bus.collision = col1_q;
    end

endmodule

// File: tb/tb_memoria_dp_param.sv
// Bench for memoria_dp_param: two instances (new-data/latency-1/clear 0x00 and
// old-data/latency-2/clear 0x5A) share one stimulus stream and are checked every cycle against
// an array-based reference model, plus a table of hand-computed vectors and corner sequences.
module tb_memoria_dp_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          clr, en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    memoria_dp_param_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    memoria_dp_param_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.clr = clr;   assign if1.clr = clr;
    assign if0.en_a = en_a; assign if1.en_a = en_a;
    assign if0.we_a = we_a; assign if1.we_a = we_a;
    assign if0.addr_a = addr_a; assign if1.addr_a = addr_a;
    assign if0.data_a = data_a; assign if1.data_a = data_a;
    assign if0.en_b = en_b; assign if1.en_b = en_b;
    assign if0.we_b = we_b; assign if1.we_b = we_b;
    assign if0.addr_b = addr_b; assign if1.addr_b = addr_b;
    assign if0.data_b = data_b; assign if1.data_b = data_b;

    memoria_dp_param #(
        .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0), .CLR_VAL(8'h00)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );

    memoria_dp_param #(
        .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1), .CLR_VAL(8'h5A)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    typedef struct packed {
        logic          va;
        logic [DW-1:0] qa;
        logic          vb;
        logic [DW-1:0] qb;
        logic          col;
    } res_t;

    logic [DW-1:0] mm [2][DEPTH];
    int            sweep_cnt;        // cycles of clearing still to go
    res_t          pend  [2];        // result waiting for its second edge (latency 2)
    res_t          shown [2];        // what the outputs should show now
    int            lat     [2] = '{1, 2};
    bit            old_rdw [2] = '{1'b0, 1'b1};
    logic [DW-1:0] clrv    [2] = '{8'h00, 8'h5A};

    task automatic model_reset();
        sweep_cnt = DEPTH;
        for (int d = 0; d < 2; d++) begin
            pend[d]  = '0;
            shown[d] = '0;
        end
    endtask

    task automatic model_step();
        bit   busy_m, acc_a, acc_b, coll;
        res_t r, rep;
        busy_m = (sweep_cnt > 0);
        acc_a  = en_a && !busy_m;
        acc_b  = en_b && !busy_m;
        coll   = acc_a && acc_b && (addr_a == addr_b) && (we_a || we_b);
        for (int d = 0; d < 2; d++) begin
            r.va  = acc_a;
            r.qa  = (acc_a && we_a && !old_rdw[d]) ? data_a : mm[d][addr_a];
            r.vb  = acc_b;
            r.qb  = (acc_b && we_b && !old_rdw[d]) ? data_b : mm[d][addr_b];
            r.col = coll;
            rep   = (lat[d] == 1) ? r : pend[d];
            pend[d] = r;
            shown[d].va  = rep.va;
            shown[d].vb  = rep.vb;
            shown[d].col = rep.col;
            if (rep.va) shown[d].qa = rep.qa;
            if (rep.vb) shown[d].qb = rep.qb;
        end
        if (busy_m) begin
            for (int d = 0; d < 2; d++) mm[d][DEPTH - sweep_cnt] = clrv[d];
            sweep_cnt--;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (acc_b && we_b && !(acc_a && we_a && addr_a == addr_b)) mm[d][addr_b] = data_b;
                if (acc_a && we_a) mm[d][addr_a] = data_a;
            end
            if (clr) sweep_cnt = DEPTH;
        end
    endtask

    task automatic cmp_dut(input int d, input logic va, input logic [DW-1:0] qa, input logic vb,
                           input logic [DW-1:0] qb, input logic col, input logic bsy);
        check($sformatf("d%0d_busy", d), {31'd0, bsy}, {31'd0, sweep_cnt > 0});
        check($sformatf("d%0d_valid_a", d), {31'd0, va}, {31'd0, shown[d].va});
        check($sformatf("d%0d_valid_b", d), {31'd0, vb}, {31'd0, shown[d].vb});
        check($sformatf("d%0d_q_a", d), {24'd0, qa}, {24'd0, shown[d].qa});
        check($sformatf("d%0d_q_b", d), {24'd0, qb}, {24'd0, shown[d].qb});
        check($sformatf("d%0d_collision", d), {31'd0, col}, {31'd0, shown[d].col});
    endtask

    task automatic compare_all();
        cmp_dut(0, if0.valid_a, if0.q_a, if0.valid_b, if0.q_b, if0.collision, if0.busy);
        cmp_dut(1, if1.valid_a, if1.q_a, if1.valid_b, if1.q_b, if1.collision, if1.busy);
    endtask

    task automatic cycle();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        clr = 1'b0; en_a = 1'b0; we_a = 1'b0; addr_a = '0; data_a = '0;
        en_b = 1'b0; we_b = 1'b0; addr_b = '0; data_b = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Returns the number of cycles busy stayed high (bounded).
    task automatic wait_sweep(output int n);
        n = 0;
        while (if0.busy === 1'b1 && n < 200) begin
            cycle();
            n++;
        end
    endtask

    // ---------------------------------------------------------------- directed vectors
    typedef struct packed {
        logic          en_a;
        logic          we_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] data_a;
        logic          en_b;
        logic          we_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data_b;
        logic          e_va;
        logic [DW-1:0] e_qa;
        logic          e_vb;
        logic [DW-1:0] e_qb;
        logic          e_col;
    } vec_t;

    vec_t vt [11];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        vt[0]  = '{1'b1, 1'b1, 6'd3,  8'hA5, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0, 6'd3,  8'h00, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 6'd5,  8'h11, 1'b1, 1'b1, 6'd5,  8'h22, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 6'd5,  8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 8'h11, 1'b0, 8'h22, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 6'd7,  8'h33, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 8'h33, 1'b0, 8'h22, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 6'd7,  8'h44, 1'b1, 1'b0, 6'd7,  8'h00, 1'b1, 8'h44, 1'b1, 8'h33, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 1'b0, 6'd7,  8'h00, 1'b0, 8'h44, 1'b1, 8'h44, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 6'd9,  8'h00, 1'b1, 1'b0, 6'd9,  8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 6'd10, 8'h00, 1'b1, 1'b1, 6'd10, 8'h66, 1'b1, 8'h00, 1'b1, 8'h66, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 6'd10, 8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 8'h66, 1'b0, 8'h66, 1'b0};
        vt[10] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 8'h66, 1'b0, 8'h66, 1'b0};

        // T1: reset, sweep length, every word cleared
        idle_inputs();
        do_reset();
        wait_sweep(n);
        check("t1_sweep_cycles", n, 64);
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1'b1; addr_a = AW'(i);
            en_b = 1'b1; addr_b = AW'(DEPTH - 1 - i);
            cycle();
            check("t1_clr_q_a", {24'd0, if0.q_a}, 32'h00);
        end
        idle_inputs();
        cycle();

        // T2-T4: table of hand-computed vectors for the latency-1 instance
        foreach (vt[i]) begin
            en_a = vt[i].en_a; we_a = vt[i].we_a; addr_a = vt[i].addr_a; data_a = vt[i].data_a;
            en_b = vt[i].en_b; we_b = vt[i].we_b; addr_b = vt[i].addr_b; data_b = vt[i].data_b;
            cycle();
            check($sformatf("vec%0d_valid_a", i), {31'd0, if0.valid_a}, {31'd0, vt[i].e_va});
            check($sformatf("vec%0d_q_a", i), {24'd0, if0.q_a}, {24'd0, vt[i].e_qa});
            check($sformatf("vec%0d_valid_b", i), {31'd0, if0.valid_b}, {31'd0, vt[i].e_vb});
            check($sformatf("vec%0d_q_b", i), {24'd0, if0.q_b}, {24'd0, vt[i].e_qb});
            check($sformatf("vec%0d_collision", i), {31'd0, if0.collision}, {31'd0, vt[i].e_col});
        end

        // Same-port write: new data vs old contents
        idle_inputs();
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd11; data_a = 8'h77;
        cycle();
        idle_inputs();
        cycle();
        check("rdw_new_q_a", {24'd0, if0.q_a}, 32'h77);
        check("rdw_old_q_a", {24'd0, if1.q_a}, 32'h5A);
        check("rdw_old_valid_a", {31'd0, if1.valid_a}, 32'd1);

        // T5: latency 2 and streaming on the registered instance
        en_a = 1'b1; addr_a = 6'd2;
        cycle();
        check("t5_lat_valid_n1", {31'd0, if1.valid_a}, 32'd0);
        addr_a = 6'd3;
        cycle();
        check("t5_valid_n2", {31'd0, if1.valid_a}, 32'd1);
        check("t5_q_n2", {24'd0, if1.q_a}, 32'h5A);
        addr_a = 6'd5;
        cycle();
        check("t5_stream_q3", {24'd0, if1.q_a}, 32'hA5);
        addr_a = 6'd7;
        cycle();
        check("t5_stream_q5", {24'd0, if1.q_a}, 32'h11);
        idle_inputs();
        cycle();
        check("t5_stream_q7", {24'd0, if1.q_a}, 32'h44);
        check("t5_stream_valid", {31'd0, if1.valid_a}, 32'd1);
        cycle();
        check("t5_hold_valid", {31'd0, if1.valid_a}, 32'd0);
        check("t5_hold_q", {24'd0, if1.q_a}, 32'h44);

        // Random traffic on a narrow address window to provoke collisions
        for (int i = 0; i < 600; i++) begin
            clr    = ($urandom_range(0, 199) == 0);
            en_a   = ($urandom_range(0, 3) != 0);
            we_a   = $urandom_range(0, 1) != 0;
            addr_a = AW'($urandom_range(0, 11));
            data_a = DW'($urandom);
            en_b   = ($urandom_range(0, 3) != 0);
            we_b   = $urandom_range(0, 1) != 0;
            addr_b = AW'($urandom_range(0, 11));
            data_b = DW'($urandom);
            cycle();
        end
        idle_inputs();
        wait_sweep(n);
        check("rand_settle", {31'd0, if0.busy}, 32'd0);

        // T6: clr, reset at sweep ptr 20, requests ignored while busy
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        en_a = 1'b1; we_a = 1'b1; addr_a = 6'd1; data_a = 8'hFF;
        for (int i = 0; i < 20; i++) cycle();
        do_reset();
        check("t6_busy_after_reset", {31'd0, if0.busy}, 32'd1);
        wait_sweep(n);
        check("t6_sweep_cycles", n, 64);
        idle_inputs();
        en_a = 1'b1; addr_a = 6'd1; en_b = 1'b1; addr_b = 6'd1;
        cycle();
        check("t6_mem0_unchanged", {24'd0, if0.q_a}, 32'h00);
        idle_inputs();
        cycle();
        check("t6_mem1_unchanged", {24'd0, if1.q_b}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
